// File: rtl/dmem_responder.sv
// Fixed-latency handshaked data memory: one request in flight, word array.
// Ports: i_clk/i_rst, i_req_* request (valid/ready), o_rsp_* one-cycle response.
module dmem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam bit DIRECT = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;

  logic [AW-1:0] q_idx;
  logic          q_ren;
  logic          q_wen;
  logic          q_err;
  logic [31:0]   q_wdata;
  logic [3:0]    q_mask;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          req_err;
  logic          enter_resp;

  logic [AW-1:0] c_idx;
  logic          c_ren;
  logic          c_wen;
  logic          c_err;
  logic [31:0]   c_wdata;
  logic [3:0]    c_mask;

  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // ren==wen covers both "read and write" and "neither".
  assign req_err = (i_req_ren == i_req_wen)
                || (|i_req_addr[1:0])
                || (i_req_addr[31:2] >= 30'(DEPTH_WORDS))
                || (i_req_mask == 4'h0);

  assign accept     = i_req_valid && o_req_ready;
  assign enter_resp = (state_nxt == S_RESP);

  // With single-cycle latency the response edge is the accept edge,
  // so the commit uses the live request instead of the latched copy.
  assign c_idx   = DIRECT ? i_req_addr[AW+1:2] : q_idx;
  assign c_ren   = DIRECT ? i_req_ren          : q_ren;
  assign c_wen   = DIRECT ? i_req_wen          : q_wen;
  assign c_err   = DIRECT ? req_err            : q_err;
  assign c_wdata = DIRECT ? i_req_wdata        : q_wdata;
  assign c_mask  = DIRECT ? i_req_mask         : q_mask;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_RESP: begin
        if (accept) state_nxt = DIRECT ? S_RESP : S_WAIT;
        else        state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (cnt <= 4'd1) state_nxt = S_RESP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = !i_rst && ((state == S_IDLE) || (state == S_RESP));
    o_rsp_valid = (state == S_RESP);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= 4'(LATENCY - 1);
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_idx   <= '0;
      q_ren   <= 1'b0;
      q_wen   <= 1'b0;
      q_err   <= 1'b0;
      q_wdata <= '0;
      q_mask  <= '0;
    end else if (accept) begin
      q_idx   <= i_req_addr[AW+1:2];
      q_ren   <= i_req_ren;
      q_wen   <= i_req_wen;
      q_err   <= req_err;
      q_wdata <= i_req_wdata;
      q_mask  <= i_req_mask;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      o_rsp_err <= c_err;
      if (c_ren && !c_err) o_rsp_rdata <= mem[c_idx] & lanes(c_mask);
      else                 o_rsp_rdata <= '0;
    end
  end

  // Storage is deliberately outside reset so contents survive an abort.
  always_ff @(posedge i_clk) begin
    if (enter_resp && c_wen && !c_err) begin
      for (int k = 0; k < 4; k++) begin
        if (c_mask[k]) mem[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances at LATENCY 1..4 on a shared bus,
// table vectors, hand sequences, and a random run against a word model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  err;
  logic [31:0] rdata [4];
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ren;
  logic        wen;
  logic [3:0]  mask;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    (g + 1),
      .INIT_FILE  ("")
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req_valid(valid[g]),
      .o_req_ready(ready[g]),
      .i_req_addr (addr),
      .i_req_ren  (ren),
      .i_req_wen  (wen),
      .i_req_wdata(wdata),
      .i_req_mask (mask),
      .o_rsp_valid(rsp_valid[g]),
      .o_rsp_rdata(rdata[g]),
      .o_rsp_err  (err[g])
    );
  end

  typedef struct {
    logic [31:0] a;
    logic        r;
    logic        w;
    logic [31:0] d;
    logic [3:0]  m;
    logic        e;
    logic [31:0] q;
  } vec_t;

  vec_t        tbl [$];
  logic [31:0] mdl [4][16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge of the response cycle.
  task automatic txn(input int k, input logic [31:0] a, input logic r,
                     input logic w, input logic [31:0] d,
                     input logic [3:0] m, output logic [31:0] q,
                     output logic e, output int lat);
    addr  = a;
    ren   = r;
    wen   = w;
    wdata = d;
    mask  = m;
    valid = '0;
    valid[k] = 1'b1;
    lat = -1;
    q   = '0;
    e   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready[k]) break;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    valid = '0;
    for (int n = 1; n <= 20; n++) begin
      if (rsp_valid[k]) begin
        lat = n;
        q   = rdata[k];
        e   = err[k];
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reference: the rules applied to a word array, lane by lane.
  task automatic model(input int k, input logic [31:0] a, input logic r,
                       input logic w, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] q,
                       output logic e);
    int wi;
    e = (r && w) || (!r && !w) || (a % 4 != 0) || ((a >> 2) >= 1024)
      || (m == 4'h0);
    q = '0;
    if (!e) begin
      wi = int'(a >> 2) - 64;
      for (int b = 0; b < 4; b++) begin
        if (m[b]) begin
          if (w) mdl[k][wi][8*b +: 8] = d[8*b +: 8];
          if (r) q[8*b +: 8] = mdl[k][wi][8*b +: 8];
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    logic [31:0] eq;
    logic [31:0] bb [4];
    logic        e;
    logic        ee;
    int          lat;
    int          seen;

    rst   = 1'b1;
    valid = '0;
    addr  = '0;
    wdata = '0;
    ren   = 1'b0;
    wen   = 1'b0;
    mask  = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_err", 32'(err), 0);
    for (int k = 0; k < 4; k++) chk("rst_rdata", rdata[k], 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ready), 32'hF);
    @(negedge clk);

    // table vectors on LATENCY=2
    tbl.push_back('{32'h10,   0, 1, 32'hDEADBEEF, 4'hF, 0, 32'h0});
    tbl.push_back('{32'h10,   1, 0, 32'h0,        4'hF, 0, 32'hDEADBEEF});
    tbl.push_back('{32'h20,   0, 1, 32'h11223344, 4'hF, 0, 32'h0});
    tbl.push_back('{32'h20,   0, 1, 32'hAA000000, 4'h8, 0, 32'h0});
    tbl.push_back('{32'h20,   1, 0, 32'h0,        4'hF, 0, 32'hAA223344});
    tbl.push_back('{32'h20,   1, 0, 32'h0,        4'h3, 0, 32'h00003344});
    tbl.push_back('{32'h0,    0, 1, 32'hCAFEF00D, 4'hF, 0, 32'h0});
    tbl.push_back('{32'h22,   0, 1, 32'hFFFFFFFF, 4'hF, 1, 32'h0});
    tbl.push_back('{32'h20,   1, 1, 32'hFFFFFFFF, 4'hF, 1, 32'h0});
    tbl.push_back('{32'h20,   0, 1, 32'hFFFFFFFF, 4'h0, 1, 32'h0});
    tbl.push_back('{32'h1000, 0, 1, 32'hFFFFFFFF, 4'hF, 1, 32'h0});
    tbl.push_back('{32'h20,   0, 0, 32'hFFFFFFFF, 4'hF, 1, 32'h0});
    tbl.push_back('{32'h22,   1, 0, 32'h0,        4'hF, 1, 32'h0});
    tbl.push_back('{32'h20,   1, 0, 32'h0,        4'hF, 0, 32'hAA223344});
    tbl.push_back('{32'h0,    1, 0, 32'h0,        4'hF, 0, 32'hCAFEF00D});
    tbl.push_back('{32'h1000, 1, 0, 32'h0,        4'hF, 1, 32'h0});
    tbl.push_back('{32'h10,   1, 0, 32'h0,        4'h6, 0, 32'h00ADBE00});
    foreach (tbl[i]) begin
      txn(1, tbl[i].a, tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].m, q, e, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 2);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_rdata", i), q, tbl[i].q);
    end

    // LATENCY=1 back-to-back reads
    for (int i = 0; i < 4; i++) begin
      bb[i] = $urandom;
      txn(0, 32'(i * 4), 0, 1, bb[i], 4'hF, q, e, lat);
      chk("bb_wlat", 32'(lat), 1);
    end
    ren   = 1'b1;
    wen   = 1'b0;
    mask  = 4'hF;
    valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i * 4);
      chk("bb_ready", 32'(ready[0]), 1);
      @(negedge clk);
      chk("bb_valid", 32'(rsp_valid[0]), 1);
      chk("bb_rdata", rdata[0], bb[i]);
    end
    valid = '0;
    @(negedge clk);
    chk("bb_idle", 32'(rsp_valid[0]), 0);

    // LATENCY=3 backpressure
    txn(2, 32'h40, 0, 1, 32'h0A0A0A0A, 4'hF, q, e, lat);
    txn(2, 32'h44, 0, 1, 32'h0B0B0B0B, 4'hF, q, e, lat);
    addr  = 32'h40;
    ren   = 1'b1;
    wen   = 1'b0;
    mask  = 4'hF;
    valid = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    addr = 32'h44;
    for (int n = 1; n <= 2; n++) begin
      chk("bp_wait_ready", 32'(ready[2]), 0);
      chk("bp_wait_valid", 32'(rsp_valid[2]), 0);
      @(negedge clk);
    end
    chk("bp_a_valid", 32'(rsp_valid[2]), 1);
    chk("bp_a_rdata", rdata[2], 32'h0A0A0A0A);
    chk("bp_resp_ready", 32'(ready[2]), 1);
    @(negedge clk);
    valid = '0;
    chk("bp_b_n1", 32'(rsp_valid[2]), 0);
    @(negedge clk);
    chk("bp_b_n2", 32'(rsp_valid[2]), 0);
    @(negedge clk);
    chk("bp_b_valid", 32'(rsp_valid[2]), 1);
    chk("bp_b_rdata", rdata[2], 32'h0B0B0B0B);
    @(negedge clk);

    // LATENCY=4 reset mid-flight
    txn(3, 32'h30, 0, 1, 32'h0BADF00D, 4'hF, q, e, lat);
    txn(3, 32'h30, 1, 0, 32'h0, 4'hF, q, e, lat);
    chk("mf_pre_rdata", q, 32'h0BADF00D);
    addr  = 32'h30;
    ren   = 1'b0;
    wen   = 1'b1;
    wdata = 32'h55555555;
    mask  = 4'hF;
    valid = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    valid = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mf_valid", 32'(rsp_valid[3]), 0);
    chk("mf_rdata", rdata[3], 0);
    chk("mf_err", 32'(err[3]), 0);
    chk("mf_ready", 32'(ready[3]), 0);
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[3]) seen++;
    end
    chk("mf_no_rsp", 32'(seen), 0);
    txn(3, 32'h30, 1, 0, 32'h0, 4'hF, q, e, lat);
    chk("mf_lat", 32'(lat), 4);
    chk("mf_kept", q, 32'h0BADF00D);

    // random run against the word model
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin
        mdl[k][i] = $urandom;
        txn(k, 32'h100 + 32'(i * 4), 0, 1, mdl[k][i], 4'hF, q, e, lat);
      end
    end
    for (int t = 0; t < 200; t++) begin
      int          k;
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
      logic        r;
      logic        w;
      k    = $urandom_range(3);
      kind = $urandom_range(19);
      a    = 32'h100 + 32'($urandom_range(15) * 4);
      d    = $urandom;
      w    = 1'($urandom_range(1));
      r    = !w;
      m    = 4'($urandom_range(15, 1));
      case (kind)
        0: a = a | 32'($urandom_range(3, 1));
        1: begin r = 1'b1; w = 1'b1; end
        2: begin r = 1'b0; w = 1'b0; end
        3: m = 4'h0;
        4: a = a | (32'($urandom_range(20'hFFFFF, 1)) << 12);
        default: ;
      endcase
      model(k, a, r, w, d, m, eq, ee);
      txn(k, a, r, w, d, m, q, e, lat);
      chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(k + 1));
      chk($sformatf("rnd%0d_err", t), 32'(e), 32'(ee));
      chk($sformatf("rnd%0d_rdata", t), q, eq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
